// File: rtl/demux1x16_buf.sv
// Registered 1-to-16 demultiplexer: one producer word is steered to one of 16
// single-entry lane buffers, each drained by its own valid/ready consumer.
module demux1x16_buf #(
  parameter int unsigned n = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [n-1:0]      in_data,
  input  logic [3:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [16*n-1:0]   out_data,
  output logic [15:0]       out_valid,
  input  logic [15:0]       out_ready,
  output logic [4:0]        occupancy
);

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  logic [15:0]     valid_q, valid_d;
  logic [16*n-1:0] data_q;
  logic [4:0]      occ_q, occ_d;

  logic [15:0]     free_s;
  logic [15:0]     drain_s;
  logic [15:0]     load_vec_s;
  logic            load_s;
  logic            load_empty_s;
  logic [4:0]      drain_cnt_s;

  // Lane free/drain decode; in_ready deliberately ignores in_valid.
  always_comb begin
    free_s       = ~valid_q | out_ready;
    drain_s      = valid_q & out_ready;
    in_ready     = free_s[in_sel];
    load_s       = in_valid & free_s[in_sel];
    if (load_s) begin
      load_vec_s = 16'h0001 << in_sel;
    end else begin
      load_vec_s = 16'h0000;
    end
    load_empty_s = load_s & ~valid_q[in_sel];
    drain_cnt_s  = popcount16(drain_s & ~load_vec_s);
  end

  // Next-state: a reload at the same edge as a drain keeps the lane valid.
  always_comb begin
    valid_d = (valid_q & ~drain_s) | load_vec_s;
    occ_d   = occ_q + {4'd0, load_empty_s} - drain_cnt_s;
  end

  // Lane valid flags and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 16'h0000;
      occ_q   <= 5'd0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Lane data buffers: only the addressed lane loads, others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {(16*n){1'b0}};
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (load_vec_s[k]) begin
          data_q[k*n +: n] <= in_data;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign occupancy = occ_q;

  demux1x16_buf_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_q),
    .occ_i     (occ_q)
  );

endmodule

// Invariant checker: the occupancy counter always tracks the lane valid popcount.
module demux1x16_buf_chk (
  input logic        clk,
  input logic        rst_n,
  input logic [15:0] valid_i,
  input logic [4:0]  occ_i
);

  // Sampled at every edge outside reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (occ_i == 5'($countones(valid_i)));
    end
  end

endmodule

// File: tb/tb_demux1x16_buf.sv
// Directed and scoreboarded random checks for demux1x16_buf.
module tb_demux1x16_buf;

  localparam int N = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    in_data;
  logic [3:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [16*N-1:0] out_data;
  logic [15:0]     out_valid;
  logic [15:0]     out_ready;
  logic [4:0]      occupancy;

  int checks   = 0;
  int failures = 0;

  demux1x16_buf #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] lane(input int k);
    return out_data[k*N +: N];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_lane(input logic [3:0] sel, input logic [N-1:0] d);
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_all();
    out_ready = 16'hFFFF;
    tick();
    out_ready = 16'h0000;
  endtask

  task automatic test_reset();
    write_lane(4'd3, 32'h0000_0033);
    write_lane(4'd7, 32'h0000_0077);
    checks++;
    if (out_valid !== 16'h0088) begin
      failures++;
      $display("FAIL reset_prefill out_valid=%h expected=%h", out_valid, 16'h0088);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 16'h0000) begin
      failures++;
      $display("FAIL reset_valid out_valid=%h expected=%h", out_valid, 16'h0000);
    end
    checks++;
    if (occupancy !== 5'd0) begin
      failures++;
      $display("FAIL reset_occ occupancy=%0d expected=0", occupancy);
    end
    checks++;
    if (lane(7) !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_data lane7=%h expected=%h", lane(7), 32'h0);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready in_ready=%b expected=1", in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_route();
    in_sel    = 4'd5;
    in_data   = 32'hDEAD_BEEF;
    in_valid  = 1'b1;
    out_ready = 16'h0000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_in_ready in_ready=%b expected=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 16'h0020) begin
      failures++;
      $display("FAIL basic_valid out_valid=%h expected=%h", out_valid, 16'h0020);
    end
    checks++;
    if (lane(5) !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_data lane5=%h expected=%h", lane(5), 32'hDEAD_BEEF);
    end
    checks++;
    if (occupancy !== 5'd1) begin
      failures++;
      $display("FAIL basic_occ occupancy=%0d expected=1", occupancy);
    end
    out_ready = 16'h0020;
    tick();
    out_ready = 16'h0000;
    checks++;
    if (out_valid !== 16'h0000 || occupancy !== 5'd0) begin
      failures++;
      $display("FAIL basic_drain out_valid=%h occ=%0d expected=0000/0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    write_lane(4'd2, 32'h0000_0011);
    in_sel    = 4'd2;
    in_data   = 32'h0000_0022;
    in_valid  = 1'b1;
    out_ready = 16'h0000;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_blocked in_ready=%b expected=0", in_ready);
    end
    tick();
    checks++;
    if (lane(2) !== 32'h0000_0011 || out_valid !== 16'h0004) begin
      failures++;
      $display("FAIL bp_hold lane2=%h valid=%h expected=00000011/0004", lane(2), out_valid);
    end
    out_ready = 16'h0004;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release in_ready=%b expected=1", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 16'h0000;
    checks++;
    if (lane(2) !== 32'h0000_0022 || out_valid !== 16'h0004) begin
      failures++;
      $display("FAIL bp_reload lane2=%h valid=%h expected=00000022/0004", lane(2), out_valid);
    end
    checks++;
    if (occupancy !== 5'd1) begin
      failures++;
      $display("FAIL bp_occ occupancy=%0d expected=1", occupancy);
    end
    drain_all();
  endtask

  task automatic test_fill_all();
    logic [3:0] probe [3] = '{4'd0, 4'd9, 4'd15};
    for (int i = 0; i < 16; i++) begin
      write_lane(4'(i), 32'(i));
    end
    checks++;
    if (occupancy !== 5'd16 || out_valid !== 16'hFFFF) begin
      failures++;
      $display("FAIL fill_full occ=%0d valid=%h expected=16/ffff", occupancy, out_valid);
    end
    checks++;
    if (lane(9) !== 32'h0000_0009) begin
      failures++;
      $display("FAIL fill_lane9 lane9=%h expected=%h", lane(9), 32'h9);
    end
    for (int j = 0; j < 3; j++) begin
      in_sel   = probe[j];
      in_data  = 32'hFFFF_0000;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL fill_in_ready sel=%0d in_ready=%b expected=0", probe[j], in_ready);
      end
    end
    in_valid = 1'b0;
    drain_all();
    checks++;
    if (occupancy !== 5'd0 || out_valid !== 16'h0000) begin
      failures++;
      $display("FAIL fill_drain occ=%0d valid=%h expected=0/0000", occupancy, out_valid);
    end
  endtask

  task automatic test_simultaneous();
    write_lane(4'd1, 32'h0000_0001);
    write_lane(4'd4, 32'h0000_0004);
    out_ready = 16'h0012;
    in_sel    = 4'd8;
    in_data   = 32'h0000_00AB;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 16'h0000;
    checks++;
    if (out_valid !== 16'h0100 || occupancy !== 5'd1) begin
      failures++;
      $display("FAIL simul_state valid=%h occ=%0d expected=0100/1", out_valid, occupancy);
    end
    checks++;
    if (lane(8) !== 32'h0000_00AB) begin
      failures++;
      $display("FAIL simul_data lane8=%h expected=%h", lane(8), 32'hAB);
    end
    drain_all();
  endtask

  task automatic test_random();
    logic [N-1:0] q [16][$];
    logic [15:0]  m_valid;
    logic         exp_rdy;
    logic [15:0]  ld;
    m_valid = 16'h0000;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = 16'($urandom);
      #1;
      exp_rdy = !m_valid[in_sel] || out_ready[in_sel];
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rand_in_ready cyc=%0d in_ready=%b expected=%b", c, in_ready, exp_rdy);
      end
      for (int k = 0; k < 16; k++) begin
        if (m_valid[k] && out_ready[k]) begin
          checks++;
          if (q[k].size() == 0 || lane(k) !== q[k][0]) begin
            failures++;
            $display("FAIL rand_deliver cyc=%0d lane=%0d data=%h", c, k, lane(k));
          end
          if (q[k].size() != 0) void'(q[k].pop_front());
        end
      end
      ld = 16'h0000;
      if (in_valid && exp_rdy) begin
        q[in_sel].push_back(in_data);
        ld[in_sel] = 1'b1;
      end
      m_valid = (m_valid & ~out_ready) | ld;
      tick();
      checks++;
      if (out_valid !== m_valid || occupancy !== 5'($countones(m_valid))) begin
        failures++;
        $display("FAIL rand_state cyc=%0d valid=%h occ=%0d expected=%h/%0d",
                 c, out_valid, occupancy, m_valid, $countones(m_valid));
      end
    end
    in_valid  = 1'b0;
    out_ready = 16'hFFFF;
    #1;
    for (int k = 0; k < 16; k++) begin
      if (m_valid[k]) begin
        checks++;
        if (q[k].size() != 1 || lane(k) !== q[k][0]) begin
          failures++;
          $display("FAIL rand_final lane=%0d data=%h pending=%0d", k, lane(k), q[k].size());
        end
      end else begin
        checks++;
        if (q[k].size() != 0) begin
          failures++;
          $display("FAIL rand_lost lane=%0d pending=%0d expected=0", k, q[k].size());
        end
      end
    end
    tick();
    out_ready = 16'h0000;
    checks++;
    if (out_valid !== 16'h0000 || occupancy !== 5'd0) begin
      failures++;
      $display("FAIL rand_empty valid=%h occ=%0d expected=0000/0", out_valid, occupancy);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 32'h0;
    in_sel    = 4'd0;
    in_valid  = 1'b0;
    out_ready = 16'h0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 16'h0000 || occupancy !== 5'd0) begin
      failures++;
      $display("FAIL init_state valid=%h occ=%0d expected=0000/0", out_valid, occupancy);
    end
    test_reset();
    test_basic_route();
    test_backpressure();
    test_fill_all();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
